hex_keypad_emulator: RTL and testbench
======================================

Name: hex_keypad_emulator

Overview:
Synthesizable model of the 4x4 hex keypad matrix, acting as the device side of the row/column scan interface.
- Accepts key-press commands through a valid/ready port and queues them.
- Replays each key by pulling the matching column low whenever the key's row is driven low.
- Used for on-board self-test and loopback of the keypad scanner and the LCD path, in place of the physical keypad.

Parameters:
- HOLD_CYCLES, 8000: press duration in clk cycles. Must be >= 1. Default covers two full scans at 100 kHz.
- RELEASE_CYCLES, 4000: minimum all-released gap after each press, in clk cycles. Must be >= 1.
- FIFO_DEPTH, 4: command queue depth. Must be a power of 2 and >= 2.
- BOUNCE_CYCLES, 16: bounce window length. Used only with the optional feature.

Ports:
- clk, in, 1: system clock (100 kHz).
- rst_n, in, 1: reset. Asynchronous assert, active-low.
- cmd_key, in, 4: hex value of the key to press.
- cmd_valid, in, 1: command valid.
- cmd_ready, out, 1: queue can accept a command.
- row, in, 4: row drive from the scanner. Active-low, one row low at a time.
- col, out, 4: column sense to the scanner. Active-low; 1111 when nothing is pressed.
- busy, out, 1: a press or release gap is in progress, or the queue is non-empty.
- pressed_key, out, 4: key currently being replayed. Holds the last key after completion.
- press_done, out, 1: one-cycle pulse at the end of each release gap.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: col=4'hF, cmd_ready=1, busy=0, pressed_key=4'h0, press_done=0. Queue is empty, FSM is in IDLE, counters are 0.
- Key layout (row r, col c). Value maps to (r,c) as follows:
  - Row 0: 1, 2, 3, A
  - Row 1: 4, 5, 6, B
  - Row 2: 7, 8, 9, C
  - Row 3: E, 0, F, D
  - All 16 values are valid; there is no illegal code.
- Handshake:
  - A command is accepted on a rising clk edge when cmd_valid && cmd_ready.
  - cmd_ready = !full, taken from the registered count.
  - A pop in the same cycle does not raise cmd_ready until the next cycle.
  - cmd_key must be stable while cmd_valid is high.
- FSM states: IDLE, PRESS, RELEASE.
  - IDLE: if the queue is non-empty, pop the head, latch pressed_key and (r,c), clear the counter, and go to PRESS. A key pushed into an empty queue is popped on the following cycle.
  - PRESS: counter increments every cycle. At HOLD_CYCLES-1, clear the counter and go to RELEASE.
  - RELEASE: col is forced to 1111. At RELEASE_CYCLES-1, pulse press_done for one cycle and go to IDLE. If the queue is non-empty, the next pop happens in the IDLE cycle.
- Column drive:
  - col is registered.
  - In PRESS: col[c] <= row[r]. All other bits are 1.
  - Otherwise col <= 4'hF.
  - Latency is one clk cycle from a row change to col.
  - Only row[r] is examined, so multiple low rows are harmless.
- busy = (state != IDLE) || !empty.
- Counters are $clog2(max(HOLD_CYCLES, RELEASE_CYCLES)+1) bits wide. They saturate at terminal count and never wrap.
- Reset mid-press: col returns to 1111 asynchronously, queued commands are discarded, and no press_done is issued.

Optional Feature:
- Macro: KEYPAD_EMU_BOUNCE_EN.
- Defined:
  - An 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) advances every cycle.
  - During the first BOUNCE_CYCLES cycles of PRESS, the contact is closed only when LFSR[0]=1.
  - During the first BOUNCE_CYCLES cycles of RELEASE, the contact is closed only when LFSR[0]=0.
  - Outside those windows, contact follows the clean behaviour.
  - Requires BOUNCE_CYCLES < HOLD_CYCLES and BOUNCE_CYCLES < RELEASE_CYCLES.
- Undefined: clean edges only. No LFSR is instantiated.

Decomposition:
- Package keypad_pkg:
  - key layout constants
  - function hex_to_rc (value to {row, col} indices), shared with the scanner's inverse map
  - FSM state typedef
  - ROW_IDLE/COL_IDLE = 4'hF
- Sub-module keypad_cmd_fifo: FIFO_DEPTH x 4-bit synchronous FIFO with full, empty and count outputs, async active-low reset.
- FSM, counters, column drive and LFSR stay in the top level.

Test Plan:
- Reset: hold rst_n low for 3 cycles -> col=4'hF, cmd_ready=1, busy=0, press_done=0, pressed_key=0.
- Push 4'h5 and drive row=4'b1101:
  - col=4'b1101 from one cycle after PRESS entry, for HOLD_CYCLES cycles.
  - row=4'b1110 during PRESS -> col=4'hF next cycle.
  - press_done pulses exactly once, HOLD_CYCLES+RELEASE_CYCLES+2 cycles after acceptance.
- Push 4'hD and hold row=4'b0111 -> col=4'b0111 during PRESS. Push 4'h0 -> col=4'b1101 only when row=4'b0111.
- Queue full (default parameters):
  - Offer 1, 2, 3, 4, 5, 6 on consecutive cycles.
  - Keys 1 to 5 are accepted; cmd_ready=0 on the 6th cycle and 6 is refused.
  - Replay order is 1, 2, 3, 4, 5, with 5 press_done pulses.
  - busy drops after the last pulse.
- Reset mid-operation: assert rst_n during PRESS of key 8 with 2 keys queued:
  - col=4'hF immediately, without waiting for clk.
  - After release: busy=0, queue empty, no further presses.
- With KEYPAD_EMU_BOUNCE_EN and BOUNCE_CYCLES=16, press key 1 with row=4'b1110:
  - col[0] toggles at least once within the first 16 PRESS cycles, then stays 0 until RELEASE.
  - Without the macro, col[0] shows exactly one falling and one rising edge.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the hex keypad emulator: key layout, key-to-matrix map, FSM states.
package keypad_pkg;

  localparam logic [3:0] ROW_IDLE = 4'hF;
  localparam logic [3:0] COL_IDLE = 4'hF;

  // Nibble (r*4+c) counted from the MSB holds the key at row r, column c.
  localparam logic [63:0] KEY_LAYOUT = 64'h123A_456B_789C_E0FD;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] c;
  } rc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_RELEASE
  } state_e;

  function automatic rc_t hex_to_rc(input logic [3:0] key);
    rc_t rc;
    rc = '0;
    for (int i = 0; i < 16; i++) begin
      if (KEY_LAYOUT[63-4*i -: 4] == key) rc = rc_t'(i[3:0]);
    end
    return rc;
  endfunction

endpackage

// File: rtl/keypad_cmd_fifo.sv
// Command queue, DEPTH x WIDTH. Pop data is combinational from the head; push is ignored
// when full and pop is ignored when empty, so the caller may drive them unconditionally.
module keypad_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_dat_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             push_ok, pop_ok;

  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;
  assign pop_dat_o = mem_q[rd_q];
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_dat_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/hex_keypad_emulator.sv
// Device side of a 4x4 keypad scan: replays queued keys as column pulls, col lags row by one clk.
// KEYPAD_EMU_BOUNCE_EN adds LFSR-driven contact bounce at the start of each press and release.
module hex_keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES    = 8000,
  parameter int RELEASE_CYCLES = 4000,
  parameter int FIFO_DEPTH     = 4,
  parameter int BOUNCE_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cmd_key,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       busy,
  output logic [3:0] pressed_key,
  output logic       press_done
);

  localparam int MAXC = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST  = CW'(RELEASE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT   = '1;

  if (HOLD_CYCLES < 1 || RELEASE_CYCLES < 1 || BOUNCE_CYCLES < 0 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("hex_keypad_emulator: illegal parameter set");
  end

  state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] key_q, key_d;
  rc_t        rc_q, rc_d;
  logic [3:0] col_q, col_d;
  logic       done_q, done_d;
  logic       pop, closed;
  logic       fifo_full, fifo_empty;
  logic [3:0] fifo_dat;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

  keypad_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(4)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (cmd_valid),
    .push_dat_i (cmd_key),
    .pop_i      (pop),
    .pop_dat_o  (fifo_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );

  assign cmd_ready   = !fifo_full;
  assign busy        = (state_q != ST_IDLE) || (fifo_cnt != '0);
  assign col         = col_q;
  assign pressed_key = key_q;
  assign press_done  = done_q;

`ifdef KEYPAD_EMU_BOUNCE_EN
  if (BOUNCE_CYCLES >= HOLD_CYCLES || BOUNCE_CYCLES >= RELEASE_CYCLES) begin : g_bad_bounce
    $error("hex_keypad_emulator: bounce window must be shorter than hold and release");
  end

  localparam logic [CW-1:0] BOUNCE_N = CW'(BOUNCE_CYCLES);
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 8'hA5;
    else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    rc_d    = rc_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          key_d   = fifo_dat;
          rc_d    = hex_to_rc(fifo_dat);
          cnt_d   = '0;
          state_d = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RELEASE: begin
        if (cnt_q == REL_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    closed = (state_q == ST_PRESS);
`ifdef KEYPAD_EMU_BOUNCE_EN
    if (cnt_q < BOUNCE_N) begin
      if (state_q == ST_PRESS)        closed = lfsr_q[0];
      else if (state_q == ST_RELEASE) closed = !lfsr_q[0];
    end
`endif
    // Only the latched key's row is sampled, so several low rows cannot ghost other columns.
    col_d = COL_IDLE;
    if (closed) col_d[rc_q.c] = row[rc_q.r];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      key_q   <= 4'h0;
      rc_q    <= '0;
      col_q   <= COL_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      rc_q    <= rc_d;
      col_q   <= col_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_hex_keypad_emulator.sv
// Bench for hex_keypad_emulator: timeline model of accepted keys plus directed literal checks.
module tb_hex_keypad_emulator;

  localparam int H = 40;
  localparam int R = 20;
  localparam int B = 16;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cmd_key;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] row;
  logic [3:0] col;
  logic       busy;
  logic [3:0] pressed_key;
  logic       press_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  hex_keypad_emulator #(
    .HOLD_CYCLES(H), .RELEASE_CYCLES(R), .FIFO_DEPTH(D), .BOUNCE_CYCLES(B)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_key(cmd_key), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .row(row), .col(col), .busy(busy), .pressed_key(pressed_key), .press_done(press_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Key value -> r*4+c position on the physical keypad.
  function automatic int key_pos(input logic [3:0] k);
    case (k)
      4'h1: return 0;   4'h2: return 1;   4'h3: return 2;   4'hA: return 3;
      4'h4: return 4;   4'h5: return 5;   4'h6: return 6;   4'hB: return 7;
      4'h7: return 8;   4'h8: return 9;   4'h9: return 10;  4'hC: return 11;
      4'hE: return 12;  4'h0: return 13;  4'hF: return 14;  default: return 15;
    endcase
  endfunction

  // Model: each accepted key is acceptance cycle a, pop cycle p, key k.
  int         m_a[$];
  int         m_p[$];
  logic [3:0] m_k[$];
  int         last_p = -100000;
  logic [3:0] row_last = 4'hF;

  always @(negedge clk) begin
    logic [3:0] e_col, e_pk;
    logic       e_busy, e_done, e_rdy, col_x;
    int         q, pos, p;
    if (!rst_n) begin
      m_a.delete(); m_p.delete(); m_k.delete();
      last_p = -100000;
    end
    e_col = 4'hF; e_pk = 4'h0; e_busy = 1'b0; e_done = 1'b0; col_x = 1'b0; q = 0;
    foreach (m_p[i]) begin
      if (m_a[i] < cyc && cyc <= m_p[i]) q++;
      if (m_a[i] < cyc && cyc <= m_p[i] + H + R) e_busy = 1'b1;
      if (cyc == m_p[i] + H + R + 1) e_done = 1'b1;
      if (cyc >= m_p[i] + 1) e_pk = m_k[i];
      if (cyc >= m_p[i] + 2 && cyc <= m_p[i] + H + 1) begin
        pos = key_pos(m_k[i]);
        e_col[pos % 4] = row_last[pos / 4];
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      if ((cyc >= m_p[i] + 2 && cyc <= m_p[i] + B + 1) ||
          (cyc >= m_p[i] + H + 2 && cyc <= m_p[i] + H + B + 1)) col_x = 1'b1;
`endif
    end
    e_rdy = (q < D);
    if (!col_x) chk("model_col", int'(col), int'(e_col));
    chk("model_ready", int'(cmd_ready), int'(e_rdy));
    chk("model_busy", int'(busy), int'(e_busy));
    chk("model_done", int'(press_done), int'(e_done));
    chk("model_key", int'(pressed_key), int'(e_pk));
    if (rst_n && cmd_valid && e_rdy) begin
      p = (cyc + 1 > last_p + H + R + 1) ? cyc + 1 : last_p + H + R + 1;
      m_a.push_back(cyc); m_p.push_back(p); m_k.push_back(cmd_key);
      last_p = p;
    end
    row_last = row;
  end

  task automatic push_key(input logic [3:0] k);
    cmd_key = k; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget && busy; n++) tick();
    chk("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    int off, done_at, pulses, lowc, falls, rises;
    logic prev;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_key = 4'h0; row = 4'hF;
    repeat (3) tick();
    chk("rst_col", int'(col), 'hF);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(press_done), 0);
    chk("rst_key", int'(pressed_key), 0);
    rst_n = 1'b1;
    tick();

    // Key 5 with row 1 driven low; row briefly moves during the press.
    row = 4'b1101;
    push_key(4'h5);
    off = 1; done_at = -1; pulses = 0; lowc = 0;
    for (int k = 0; k < H + R + 10; k++) begin
      if (press_done) begin
        pulses++;
        if (done_at < 0) done_at = off;
      end
      if (col == 4'b1101) lowc++;
      if (off == 3)  chk("k5_col", int'(col), 'b1101);
      if (off == 11) chk("k5_row_moved", int'(col), 'hF);
      row = (off == 10) ? 4'b1110 : 4'b1101;
      tick(); off++;
    end
    chk("k5_done_latency", done_at, H + R + 2);
    chk("k5_done_pulses", pulses, 1);
    chk("k5_low_cycles", lowc, H - 1);
    chk("k5_key_held", int'(pressed_key), 5);

    // Key D and key 0 both live on row 3.
    row = 4'b0111;
    push_key(4'hD); tick(); tick();
    chk("kD_col", int'(col), 'b0111);
    wait_idle(H + R + 10);
    push_key(4'h0); tick(); tick();
    chk("k0_col_row3", int'(col), 'b1101);
    row = 4'b1011; tick();
    chk("k0_col_row2", int'(col), 'hF);
    row = 4'b0111;
    wait_idle(H + R + 10);

    // Queue full: six offers on back-to-back cycles.
    row = 4'b1110;
    for (int i = 1; i <= 6; i++) begin
      cmd_key = 4'(i); cmd_valid = 1'b1;
      chk("qfull_ready", int'(cmd_ready), (i < 6) ? 1 : 0);
      tick();
    end
    cmd_valid = 1'b0;
    pulses = 0;
    for (int n = 0; n < 6 * (H + R + 2); n++) begin
      if (press_done) begin
        if (pulses < 5) chk("replay_order", int'(pressed_key), pulses + 1);
        pulses++;
      end
      tick();
    end
    chk("replay_count", pulses, 5);
    chk("replay_busy", int'(busy), 0);

    // Reset during the press of key 8 with two more keys queued.
    row = 4'b1011;
    cmd_valid = 1'b1;
    cmd_key = 4'h8; tick();
    cmd_key = 4'h3; tick();
    cmd_key = 4'h9; tick();
    cmd_valid = 1'b0;
    repeat (7) tick();
    chk("k8_col", int'(col), 'b1101);
    #2 rst_n = 1'b0;
    #1 chk("async_col", int'(col), 'hF);
    repeat (3) tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 2 * (H + R); n++) begin
      if (press_done) pulses++;
      tick();
    end
    chk("post_rst_done", pulses, 0);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_col", int'(col), 'hF);

    // Key 1 on row 0 / col 0: count edges on col[0].
    row = 4'b1110;
    push_key(4'h1);
    prev = col[0]; falls = 0; rises = 0; lowc = 0;
    for (int n = 1; n < H + R + 8; n++) begin
      if (prev && !col[0]) falls++;
      if (!prev && col[0]) rises++;
      if (n >= B + 3 && n <= H + 2 && !col[0]) lowc++;
      prev = col[0];
      tick();
    end
`ifdef KEYPAD_EMU_BOUNCE_EN
    chk("bounce_settled_low", lowc, H - B);
`else
    chk("clean_falls", falls, 1);
    chk("clean_rises", rises, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
